// File: rtl/result_writer_bram_pkg.sv
// Shared definitions for the fully-connected datapath BRAM-side blocks.
// The FSM encodings are common to the BRAM data mover and the result writer,
// so both report the same idle/run/done status to the control registers.
package result_writer_bram_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // One result lane per core.
   localparam int NUM_LANES = 4;

endpackage

// File: rtl/result_writer_bram_sat.sv
// sat_s32_to_s8: clamps a signed 32-bit lane result to the signed 8-bit range.
// Only present in builds with RESULT_WRITER_PACK8_EN, the sole user of the clamp.
`ifdef RESULT_WRITER_PACK8_EN
module sat_s32_to_s8 (
   input  logic signed [31:0] din,
   output logic        [7:0]  dout
);

   // Saturate above 127 and below -128, otherwise pass the low byte through.
   always_comb begin
      dout = din[7:0];
      if (din > 32'sd127) begin
         dout = 8'h7F;
      end else if (din < -32'sd128) begin
         dout = 8'h80;
      end
   end

endmodule
`endif

// File: rtl/result_writer_bram.sv
// result_writer_bram: write-back end of the fully-connected datapath.
// Accepts 4-lane result beats and writes them to a single-port result BRAM
// at consecutive addresses starting from 0 (address wraps at 2^AWIDTH).
// Optional build macro RESULT_WRITER_PACK8_EN: each lane is clamped to s8 and
// the four bytes are packed into one word per beat (lane 0 in [31:24]).
// Without the macro each beat is serialised as four words, lane 0 first.
//
// Handshake: a beat transfers on a rising clk edge where i_valid && o_ready.
// o_ready depends only on registered state, never on i_valid; the source may
// hold i_valid and data until it sees the transfer, and i_valid is ignored
// outside S_RUN or once num_cnt beats have been accepted.
module result_writer_bram
   import result_writer_bram_pkg::*;
#(
   parameter int CNT_BIT  = 31,
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 12,
   parameter int MEM_SIZE = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   output logic               o_idle,
   output logic               o_write,
   output logic               o_done,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [DWIDTH-1:0]  i_result_0,
   input  logic [DWIDTH-1:0]  i_result_1,
   input  logic [DWIDTH-1:0]  i_result_2,
   input  logic [DWIDTH-1:0]  i_result_3,
   output logic [AWIDTH-1:0]  addr_b,
   output logic               ce_b,
   output logic               we_b,
   output logic [DWIDTH-1:0]  d_b,
   input  logic [DWIDTH-1:0]  q_b
);

   state_t             state;
   state_t             state_n;
   logic [CNT_BIT-1:0] num_cnt;
   logic [CNT_BIT-1:0] beat_cnt;
   logic [CNT_BIT-1:0] accept_cnt;
   logic [CNT_BIT-1:0] addr_cnt;
   logic               busy;
   logic [AWIDTH-1:0]  addr_hold;
   logic [DWIDTH-1:0]  data_hold;
   logic [DWIDTH-1:0]  wr_data;
   logic [DWIDTH-1:0]  lane_in [NUM_LANES];
   logic               last_lane;
   logic               accept;
   logic               final_write;
   logic               unused_ok;

   // The BRAM read port is not used by a pure writer.
   assign unused_ok = ^{q_b, MEM_SIZE[0]};

   assign lane_in[0] = i_result_0;
   assign lane_in[1] = i_result_1;
   assign lane_in[2] = i_result_2;
   assign lane_in[3] = i_result_3;

`ifdef RESULT_WRITER_PACK8_EN
   logic [7:0]        sat [NUM_LANES];
   logic [DWIDTH-1:0] pack_word_q;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_sat
      sat_s32_to_s8 u_sat (
         .din  (lane_in[k]),
         .dout (sat[k])
      );
   end

   // Every busy cycle writes a whole packed beat.
   assign last_lane = 1'b1;
   assign wr_data   = pack_word_q;

   // Capture the packed word of an accepted beat for the following write cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pack_word_q <= '0;
      end else if (accept) begin
         pack_word_q <= {sat[0], sat[1], sat[2], sat[3]};
      end
   end
`else
   logic [DWIDTH-1:0] lane_q [NUM_LANES];
   logic [1:0]        lane_idx;

   assign last_lane = (lane_idx == 2'd3);
   assign wr_data   = lane_q[lane_idx];

   // Hold the accepted beat and step through its lanes, lane 0 first.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q   <= '{default: '0};
         lane_idx <= 2'd0;
      end else if (accept) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            lane_q[k] <= lane_in[k];
         end
         lane_idx <= 2'd0;
      end else if (busy) begin
         lane_idx <= lane_idx + 2'd1;
      end
   end
`endif

   // A new beat is taken only when the last word of the current one is going out.
   assign o_ready     = (state == S_RUN) && (accept_cnt < num_cnt) && (!busy || last_lane);
   assign accept      = i_valid && o_ready;
   assign final_write = busy && last_lane && ((beat_cnt + CNT_BIT'(1)) == num_cnt);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic; the unused encoding falls back to idle.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (i_run) state_n = S_RUN;
         S_RUN: begin
            if (num_cnt == '0) begin
               state_n = S_DONE;
            end else if (final_write) begin
               state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      o_idle  = (state == S_IDLE);
      o_write = (state == S_RUN);
      o_done  = (state == S_DONE);
   end

   // Counters, busy flag and last-written address/data.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_cnt    <= '0;
         beat_cnt   <= '0;
         accept_cnt <= '0;
         addr_cnt   <= '0;
         busy       <= 1'b0;
         addr_hold  <= '0;
         data_hold  <= '0;
      end else begin
         if ((state == S_IDLE) && i_run) begin
            num_cnt    <= i_num_cnt;
            beat_cnt   <= '0;
            accept_cnt <= '0;
            addr_cnt   <= '0;
         end else begin
            if (accept) begin
               accept_cnt <= accept_cnt + CNT_BIT'(1);
            end
            if (busy) begin
               addr_cnt  <= addr_cnt + CNT_BIT'(1);
               addr_hold <= addr_cnt[AWIDTH-1:0];
               data_hold <= wr_data;
               if (last_lane) begin
                  beat_cnt <= beat_cnt + CNT_BIT'(1);
               end
            end
         end
         busy <= accept || (busy && !last_lane);
      end
   end

   // BRAM port: write while busy, otherwise keep the last address and data.
   assign ce_b   = busy;
   assign we_b   = busy;
   assign addr_b = busy ? addr_cnt[AWIDTH-1:0] : addr_hold;
   assign d_b    = busy ? wr_data : data_hold;

endmodule

// File: tb/tb_result_writer_bram.sv
// Bench for result_writer_bram: a per-cycle vector table for the basic run,
// hand-written sequences for the multi-cycle corners, and a write scoreboard.
// A second instance with AWIDTH=3 shares all inputs to exercise address wrap.
module tb_result_writer_bram;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_run;
   logic [30:0] i_num_cnt;
   logic        i_valid;
   logic [31:0] i_result_0, i_result_1, i_result_2, i_result_3;

   logic        o_idle, o_write, o_done, o_ready;
   logic [11:0] addr_b;
   logic        ce_b, we_b;
   logic [31:0] d_b;

   logic        o_idle3, o_write3, o_done3, o_ready3;
   logic [2:0]  addr3_b;
   logic        ce3_b, we3_b;
   logic [31:0] d3_b;

   int total = 0;
   int bad   = 0;
   logic        mon_en  = 1'b0;
   logic        mon3_en = 1'b0;
   logic [43:0] exp_q[$];
   logic [34:0] exp3_q[$];

   typedef struct {
      logic        run;
      logic [30:0] num;
      logic        valid;
      logic [31:0] r0, r1, r2, r3;
      logic        idle, write, done, ready, we;
      logic [11:0] addr;
      logic [31:0] data;
   } vec_t;

   vec_t tbl[11];

   result_writer_bram dut (
      .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
      .o_idle(o_idle), .o_write(o_write), .o_done(o_done),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_result_0(i_result_0), .i_result_1(i_result_1),
      .i_result_2(i_result_2), .i_result_3(i_result_3),
      .addr_b(addr_b), .ce_b(ce_b), .we_b(we_b), .d_b(d_b), .q_b(32'h0)
   );

   result_writer_bram #(.AWIDTH(3), .MEM_SIZE(8)) dut3 (
      .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
      .o_idle(o_idle3), .o_write(o_write3), .o_done(o_done3),
      .i_valid(i_valid), .o_ready(o_ready3),
      .i_result_0(i_result_0), .i_result_1(i_result_1),
      .i_result_2(i_result_2), .i_result_3(i_result_3),
      .addr_b(addr3_b), .ce_b(ce3_b), .we_b(we3_b), .d_b(d3_b), .q_b(32'h0)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog act=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h required=%h", name, act, exp);
      end
   endtask

   // Write scoreboards, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en && (we_b || ce_b)) begin
         logic [43:0] e;
         check("ce_eq_we", ce_b, we_b);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_write act=addr %0d data %h required=no write", addr_b, d_b);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", addr_b, e[43:32]);
            check("wr_data", d_b, e[31:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (mon3_en && we3_b) begin
         logic [34:0] e;
         if (exp3_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_write3 act=addr %0d required=no write", addr3_b);
         end else begin
            e = exp3_q.pop_front();
            check("wr3_addr", addr3_b, e[34:32]);
            check("wr3_data", d3_b, e[31:0]);
         end
      end
   end

   // Driver tasks; every task returns 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [30:0] num);
      i_run     = 1'b1;
      i_num_cnt = num;
      step();
      i_run = 1'b0;
      check("run_entered", o_write, 1'b1);
   endtask

   task automatic set_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
      i_result_0 = a;
      i_result_1 = b;
      i_result_2 = c;
      i_result_3 = d;
   endtask

   task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
      int n = 0;
      set_beat(a, b, c, d);
      i_valid = 1'b1;
      while (!o_ready && n < 50) begin
         step();
         n++;
      end
      check("accept_in_budget", o_ready, 1'b1);
      step();
      i_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!o_done && n < 100) begin
         step();
         n++;
      end
      check(name, o_done, 1'b1);
      step();
      check("idle_after_done", o_idle, 1'b1);
      check("done_one_cycle", o_done, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      i_run = 1'b0;
      i_num_cnt = '0;
      i_valid = 1'b0;
      set_beat(0, 0, 0, 0);
      repeat (3) step();
      reset = 1'b0;

      // Reset state.
      check("rst_idle", o_idle, 1'b1);
      check("rst_write", o_write, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_ready", o_ready, 1'b0);
      check("rst_ce", ce_b, 1'b0);
      check("rst_we", we_b, 1'b0);
      check("rst_addr", addr_b, 12'd0);
      check("rst_data", d_b, 32'd0);
      step();

`ifndef RESULT_WRITER_PACK8_EN
      // Test 1: num_cnt=2, valid held high, two beats written to addr 0..7.
      tbl[0]  = '{1'b1, 31'd2, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 32'd0};
      tbl[1]  = '{1'b0, 31'd2, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 32'd1};
      tbl[2]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd1, 32'd2};
      tbl[3]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd2, 32'd3};
      tbl[4]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd3, 32'd4};
      tbl[5]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd4, 32'd5};
      tbl[6]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd5, 32'd6};
      tbl[7]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd6, 32'd7};
      tbl[8]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'd7, 32'd8};
      tbl[9]  = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 32'd0};
      tbl[10] = '{1'b0, 31'd2, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 32'd0};
      for (int i = 0; i < 11; i++) begin
         i_run     = tbl[i].run;
         i_num_cnt = tbl[i].num;
         i_valid   = tbl[i].valid;
         set_beat(tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].r3);
         step();
         check($sformatf("t1_idle[%0d]", i), o_idle, tbl[i].idle);
         check($sformatf("t1_write[%0d]", i), o_write, tbl[i].write);
         check($sformatf("t1_done[%0d]", i), o_done, tbl[i].done);
         check($sformatf("t1_ready[%0d]", i), o_ready, tbl[i].ready);
         check($sformatf("t1_we[%0d]", i), we_b, tbl[i].we);
         if (tbl[i].we) begin
            check($sformatf("t1_addr[%0d]", i), addr_b, tbl[i].addr);
            check($sformatf("t1_data[%0d]", i), d_b, tbl[i].data);
         end
      end
      i_valid = 1'b0;
      step();
      mon_en = 1'b1;

      // Test 2: num_cnt=0, no writes, done two cycles after run.
      start(31'd0);
      check("t2_ready_run", o_ready, 1'b0);
      check("t2_no_done_yet", o_done, 1'b0);
      step();
      check("t2_done", o_done, 1'b1);
      check("t2_ready_done", o_ready, 1'b0);
      step();
      check("t2_idle", o_idle, 1'b1);
      step();

      // Test 3: num_cnt=3, gapped beats, extra valid ignored.
      for (int b = 0; b < 3; b++) begin
         for (int l = 0; l < 4; l++) begin
            exp_q.push_back({12'(4 * b + l), 32'(256 * (b + 1) + l)});
         end
      end
      start(31'd3);
      send_beat(32'h100, 32'h101, 32'h102, 32'h103);
      check("t3_ready_lane0", o_ready, 1'b0);
      step();
      check("t3_ready_lane1", o_ready, 1'b0);
      step();
      check("t3_ready_lane2", o_ready, 1'b0);
      step();
      check("t3_ready_lane3", o_ready, 1'b1);
      repeat (5) step();
      check("t3_ready_gap", o_ready, 1'b1);
      send_beat(32'h200, 32'h201, 32'h202, 32'h203);
      send_beat(32'h300, 32'h301, 32'h302, 32'h303);
      set_beat(32'hDEAD, 32'hBEEF, 32'hDEAD, 32'hBEEF);
      i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t3_ready_full[%0d]", k), o_ready, 1'b0);
         step();
      end
      wait_done("t3_done");
      i_valid = 1'b0;
      check("t3_all_written", exp_q.size(), 0);
      step();

      // Test 4: reset after the lane-1 write discards the beat.
      exp_q.push_back({12'd0, 32'd41});
      exp_q.push_back({12'd1, 32'd42});
      start(31'd1);
      send_beat(32'd41, 32'd42, 32'd43, 32'd44);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t4_ce", ce_b, 1'b0);
      check("t4_we", we_b, 1'b0);
      check("t4_idle", o_idle, 1'b1);
      check("t4_ready", o_ready, 1'b0);
      check("t4_discarded", exp_q.size(), 0);
      for (int l = 0; l < 4; l++) begin
         exp_q.push_back({12'(l), 32'(51 + l)});
      end
      start(31'd1);
      send_beat(32'd51, 32'd52, 32'd53, 32'd54);
      wait_done("t4_done");
      check("t4_all_written", exp_q.size(), 0);

      // Test 5: AWIDTH=3 wraps after 8 words; 12-bit instance stays linear.
      for (int b = 0; b < 3; b++) begin
         for (int l = 0; l < 4; l++) begin
            exp_q.push_back({12'(4 * b + l), 32'(32'hA00 + 16 * b + l)});
            exp3_q.push_back({3'((4 * b + l) % 8), 32'(32'hA00 + 16 * b + l)});
         end
      end
      mon3_en = 1'b1;
      start(31'd3);
      send_beat(32'hA00, 32'hA01, 32'hA02, 32'hA03);
      send_beat(32'hA10, 32'hA11, 32'hA12, 32'hA13);
      send_beat(32'hA20, 32'hA21, 32'hA22, 32'hA23);
      wait_done("t5_done");
      check("t5_all_written", exp_q.size(), 0);
      check("t5_all_written3", exp3_q.size(), 0);
      mon3_en = 1'b0;
`else
      mon_en = 1'b1;

      // Test 6: saturating pack, one write at addr 0, done on the next cycle.
      exp_q.push_back({12'd0, 32'h7FFB807F});
      start(31'd1);
      send_beat(32'd300, -32'sd5, -32'sd1000, 32'd127);
      check("t6_we", we_b, 1'b1);
      step();
      check("t6_done", o_done, 1'b1);
      check("t6_we_after", we_b, 1'b0);
      step();
      check("t6_idle", o_idle, 1'b1);
      check("t6_all_written", exp_q.size(), 0);

      // Back-to-back packed beats at one per cycle.
      exp_q.push_back({12'd0, 32'h01020304});
      exp_q.push_back({12'd1, 32'hFFFEFDFC});
      exp_q.push_back({12'd2, 32'h7F800007});
      start(31'd3);
      send_beat(32'd1, 32'd2, 32'd3, 32'd4);
      check("t6_ready_b1", o_ready, 1'b1);
      send_beat(-32'sd1, -32'sd2, -32'sd3, -32'sd4);
      check("t6_ready_b2", o_ready, 1'b1);
      send_beat(32'd128, -32'sd129, 32'd0, 32'd7);
      check("t6_ready_full", o_ready, 1'b0);
      wait_done("t6_done3");
      check("t6_all_written3", exp_q.size(), 0);
`endif

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/result_writer_bram.md
Name: result_writer_bram

Overview:
Write-back end of the fully-connected datapath. It accepts 4-lane result beats (lanes 0..3, one per core) through a valid/ready handshake and writes them into a single-port result BRAM at consecutive addresses from 0. The block is started by the same run/num_cnt control as the BRAM data mover and reports idle, busy and done status to the control registers.

Parameters:
CNT_BIT, 31, width of beat count and address counter
DWIDTH, 32, BRAM data width and per-lane result width
AWIDTH, 12, BRAM address width
MEM_SIZE, 4096, BRAM depth in words (informational; the address is truncated to AWIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_run  in  1  start pulse, sampled only in S_IDLE
i_num_cnt  in  CNT_BIT  number of result beats to accept
o_idle  out  1  FSM in S_IDLE
o_write  out  1  FSM in S_RUN
o_done  out  1  one-cycle pulse, FSM in S_DONE
i_valid  in  1  result beat valid
o_ready  out  1  block can accept a beat this cycle
i_result_0..i_result_3  in  DWIDTH each  lane results; lane 0 is the MSB-byte core
addr_b  out  AWIDTH  BRAM address
ce_b  out  1  BRAM chip enable
we_b  out  1  BRAM write enable
d_b  out  DWIDTH  BRAM write data
q_b  in  DWIDTH  unused

Behaviour:
- Clocking: all state changes on posedge clk. reset=1 at any edge clears everything. After reset: state S_IDLE, counters 0, holding register 0, busy 0, o_ready 0, ce_b/we_b 0, addr_b 0, d_b 0, o_done 0. An in-flight beat is discarded on reset.
- FSM states (2 bits): S_IDLE=00, S_RUN=01, S_DONE=10. 11 is unreachable and recovers to S_IDLE next cycle.
- S_IDLE -> S_RUN on i_run. On that edge, num_cnt is captured from i_num_cnt, and beat_cnt, accept_cnt and addr_cnt are cleared.
- If the captured num_cnt==0: S_RUN -> S_DONE on the next cycle with no writes. o_ready stays 0.
- i_run in S_RUN or S_DONE is ignored; i_num_cnt is not re-sampled.
- Handshake: a beat is accepted when i_valid && o_ready at a clock edge.
- o_ready = (state==S_RUN) && (accept_cnt<num_cnt) && (!busy || lane_idx==3).
- i_valid outside S_RUN, or after num_cnt beats have been accepted, is ignored.
- Serialisation: an accepted beat loads 4 lanes into the holding register and sets busy=1 with lane_idx=0.
- Each busy cycle drives ce_b=we_b=1, addr_b=addr_cnt[AWIDTH-1:0] and d_b=lane[lane_idx]. On the clock edge, addr_cnt increments and lane_idx increments.
- On the lane_idx==3 cycle, beat_cnt increments. If a beat is accepted that same cycle, busy stays 1 with lane_idx=0; otherwise busy clears.
- Latency: a beat accepted at edge t is written over the 4 cycles following t. Sustained throughput is 1 beat per 4 cycles, with no bubble between beats.
- Memory outputs: ce_b=we_b=0 when not busy. d_b and addr_b are don't-care but hold their last value.
- Completion: S_RUN -> S_DONE on the edge where the final lane of beat num_cnt-1 is written. S_DONE -> S_IDLE unconditionally. o_done is high for exactly 1 cycle.
- Wrap-around: addr_cnt is CNT_BIT wide, and addr_b is its low AWIDTH bits. With 4*num_cnt > 2^AWIDTH, addresses wrap to 0 and overwrite earlier data; no error is flagged.

Optional Feature:
Macro: RESULT_WRITER_PACK8_EN.
- Defined:
  - Each lane is clamped as a signed 32-bit value to the signed 8-bit range [-128,127].
  - The four bytes are packed as d_b = {sat0,sat1,sat2,sat3}, with lane 0 in [31:24].
  - One write per beat, in the cycle after acceptance.
  - o_ready = (state==S_RUN) && (accept_cnt<num_cnt), so 1 beat per cycle.
  - Total words written = num_cnt. DONE follows the write of beat num_cnt-1.
- Undefined: 4-word serialisation as described above; no saturation logic is synthesised.

Decomposition:
- Shared package holds the FSM state encodings S_IDLE/S_RUN/S_DONE (shared with the BRAM data mover) and the constant NUM_LANES=4.
- Natural sub-module: sat_s32_to_s8 (combinational clamp), instantiated 4 times only under RESULT_WRITER_PACK8_EN.

Test Plan:
1. num_cnt=2 with i_valid held high and beats {1,2,3,4},{5,6,7,8} -> writes addr 0..7 with data 1..8 in 8 consecutive cycles; o_done pulses 1 cycle after the addr-7 write; o_idle returns.
2. num_cnt=0 with i_run pulse -> no we_b; o_done pulses 2 cycles after i_run; o_ready never asserts.
3. num_cnt=3 with i_valid gapped (beat, 5 idle cycles, beat, beat) -> addresses 0..11 contiguous; o_ready low during serialisation except on lane 3; extra i_valid after 3 beats is ignored.
4. Reset mid-beat (reset asserted after the lane-1 write) -> next cycle ce_b=we_b=0, state IDLE, o_ready=0; a fresh run with num_cnt=1 writes from addr 0.
5. AWIDTH=3, num_cnt=3 -> 12 writes at addresses 0..7 then 0..3; done after 12 writes.
6. RESULT_WRITER_PACK8_EN with beat {300,-5,-1000,127}, num_cnt=1 -> single write addr 0, d_b=32'h7FFB807F; o_done on the next cycle.
